mult_div_unit: RTL

- Parametrised multi-cycle integer multiply/divide unit for the CPU datapath; successor to the fixed 32-bit Booth multiplier.
- Performs signed or unsigned radix-2 Booth multiplication and restoring division, one iteration per clock.
- Uses a start/busy/done handshake and writes results into hi/lo registers.
- Adds over the previous block: width parameter, divide mode, unsigned mode, divide-by-zero detection, and a defined latency.

---
 rtl/mult_div_pkg.sv | 15 +
 rtl/md_step.sv | 54 +++++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mult_div_pkg;

  // Control states: idle, iterating, final correction/writeback
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Operation select encoding
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/md_step.sv
// One iteration of either a radix-2 Booth multiply step or a restoring
// divide step. Purely combinational; the caller owns all state.
module md_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op_i,
  input  logic [WIDTH:0]   hi_i,    // Booth partial sum / division remainder
  input  logic [WIDTH-1:0] lo_i,    // multiplier bits / dividend-quotient bits
  input  logic             lsb_i,   // Booth q-1 bit
  input  logic [WIDTH:0]   opnd_i,  // extended multiplicand / divisor magnitude
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             lsb_o
);

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;

  // Next accumulator value for the selected algorithm
  always_comb begin
    booth_sum = hi_i;
    // Remainder never exceeds the divisor, so its top bit is always zero here
    rem_shift = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {1'b0, opnd_i};
    hi_o      = hi_i;
    lo_o      = lo_i;
    lsb_o     = lsb_i;
    if (op_i == OP_MULT) begin
      case ({lo_i[0], lsb_i})
        2'b01:   booth_sum = hi_i + opnd_i;
        2'b10:   booth_sum = hi_i - opnd_i;
        default: booth_sum = hi_i;
      endcase
      // Arithmetic shift right of {hi, lo, q-1}
      hi_o  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      lo_o  = {booth_sum[0], lo_i[WIDTH-1:1]};
      lsb_o = lo_i[0];
    end else begin
      // Keep the trial difference only when it did not borrow
      if (!trial[WIDTH+1]) begin
        hi_o = trial[WIDTH:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = rem_shift;
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
      lsb_o = 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply (Booth) and divide (restoring) unit
// with start/busy/done handshake and hi/lo result registers.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             op_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e        state_q;
  logic             op_q, signed_q, a_neg_q, b_neg_q, lsb_q;
  logic [WIDTH:0]   opnd_q, acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_hi_d;
  logic [WIDTH-1:0] step_lo_d;
  logic             step_lsb_d;

  // Operand signs and magnitudes as presented at the start request
  always_comb begin
    a_neg = is_signed_i & a_i[WIDTH-1];
    b_neg = is_signed_i & b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  md_step #(.WIDTH(WIDTH)) u_step (
    .op_i   (op_q),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .lsb_i  (lsb_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi_d),
    .lo_o   (step_lo_d),
    .lsb_o  (step_lsb_d)
  );

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      op_q       <= 1'b0;
      signed_q   <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      lsb_q      <= 1'b0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_q       <= op_i;
            signed_q   <= is_signed_i;
            a_neg_q    <= a_neg;
            b_neg_q    <= b_neg;
            lsb_q      <= 1'b0;
            cnt_q      <= CNT_W'(WIDTH);
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            if (op_i == OP_MULT) begin
              opnd_q   <= {a_neg, a_i};
              acc_hi_q <= '0;
              acc_lo_q <= b_i;
              state_q  <= ST_RUN;
            end else begin
              opnd_q   <= {1'b0, b_mag};
              acc_lo_q <= a_mag;
              if (b_i == '0) begin
                // Park the raw dividend where FIX reports it
                acc_hi_q <= {1'b0, a_i};
                state_q  <= ST_FIX;
              end else begin
                acc_hi_q <= '0;
                state_q  <= ST_RUN;
              end
            end
          end
        end
        ST_RUN: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          lsb_q    <= step_lsb_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (op_q == OP_MULT) begin
            // Booth treats the multiplier as signed; an unsigned multiplier
            // with its top bit set needs one more add of A at weight 2^W.
            hi_q <= (!signed_q && lsb_q) ? acc_hi_q[WIDTH-1:0] + opnd_q[WIDTH-1:0]
                                         : acc_hi_q[WIDTH-1:0];
            lo_q <= acc_lo_q;
          end else if (opnd_q == '0) begin
            hi_q       <= acc_hi_q[WIDTH-1:0];
            lo_q       <= '1;
            div_zero_q <= 1'b1;
          end else begin
            // Truncating division: remainder follows the dividend's sign
            hi_q <= a_neg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
            lo_q <= (a_neg_q ^ b_neg_q) ? -acc_lo_q : acc_lo_q;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
